vga_sync_generator: RTL and testbench

Generates 640x480 @ 60 Hz VGA timing from the 100 MHz system clock. Produces the pixel-rate enable, the current pixel coordinates `x`/`y`, `blank`, and the `hsync`/`vsync` pins. It is the source end of the pixel-coordinate interface: the renderer, the sprite/collider signal generators and the game-logic frame update all consume its outputs.

---
 rtl/vga_timing_pkg.sv | 27 ++
 rtl/vga_sync_generator_if.sv | 25 ++
 rtl/vga_sync_generator_pixel_clk_enable.sv | 44 ++++
 rtl/vga_sync_generator.sv | 110 +++++++++++
 tb/tb_vga_sync_generator.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: shared 640x480 @ 60 Hz VGA timing constants.
//   VGA_H_* / VGA_V_*  : active, front porch, sync, back porch (pixels / lines)
//   VGA_H_TOTAL/V_TOTAL: full line / frame lengths
//   VGA_SYNC_ACTIVE    : default level of hsync/vsync during the sync pulse
//   COORD_W            : width of the x/y coordinate buses
package vga_timing_pkg;

    localparam int unsigned VGA_H_ACTIVE = 640;
    localparam int unsigned VGA_H_FP     = 16;
    localparam int unsigned VGA_H_SYNC   = 96;
    localparam int unsigned VGA_H_BP     = 48;

    localparam int unsigned VGA_V_ACTIVE = 480;
    localparam int unsigned VGA_V_FP     = 10;
    localparam int unsigned VGA_V_SYNC   = 2;
    localparam int unsigned VGA_V_BP     = 33;

    localparam int unsigned VGA_H_TOTAL =
        VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
    localparam int unsigned VGA_V_TOTAL =
        VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

    localparam logic VGA_SYNC_ACTIVE = 1'b0;

    localparam int unsigned COORD_W = 10;

endpackage

// File: rtl/vga_sync_generator_if.sv
// vga_sync_generator_if: pixel-coordinate interface.
//   master : the timing generator (drives everything)
//   slave  : renderer / sprite generators / frame-update logic
//   pixel_tick, x, y, blank, hsync, vsync, frame_start, vblank_start
interface vga_sync_generator_if;
    import vga_timing_pkg::*;

    logic               pixel_tick;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic               blank;
    logic               hsync;
    logic               vsync;
    logic               frame_start;
    logic               vblank_start;

    modport master (
        output pixel_tick, x, y, blank, hsync, vsync, frame_start, vblank_start
    );

    modport slave (
        input  pixel_tick, x, y, blank, hsync, vsync, frame_start, vblank_start
    );

endinterface

// File: rtl/vga_sync_generator_pixel_clk_enable.sv
// pixel_clk_enable: divides the system clock into a one-clk pixel enable.
//   clk    : system clock
//   reset  : synchronous, active-low reset
//   tick_o : high for one clk every CLK_DIV clks
module pixel_clk_enable #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    output logic tick_o
);

    localparam int unsigned PHASE_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(CLK_DIV - 1);

    if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_div
        $error("pixel_clk_enable: CLK_DIV must be in 1..16");
    end

    logic [PHASE_W-1:0] phase_q, phase_d;
    // run_q holds the phase at 0 for the first cycle after release, so the
    // first tick lands in cycle CLK_DIV-1 (cycle 0 even when CLK_DIV = 1).
    logic               run_q;

    always_comb begin
        phase_d = phase_q;
        if (run_q) begin
            phase_d = (phase_q == PHASE_LAST) ? '0 : phase_q + PHASE_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            phase_q <= '0;
            run_q   <= 1'b0;
        end else begin
            phase_q <= phase_d;
            run_q   <= 1'b1;
        end
    end

    assign tick_o = reset && run_q && (phase_q == PHASE_LAST);

endmodule

// File: rtl/vga_sync_generator.sv
// vga_sync_generator: VGA timing source (default 640x480 @ 60 Hz from 100 MHz).
//   clk   : system clock
//   reset : synchronous, active-low reset
//   pix   : master side of vga_sync_generator_if
//           (pixel_tick, x, y, blank, hsync, vsync, frame_start, vblank_start)
module vga_sync_generator
    import vga_timing_pkg::*;
#(
    parameter int unsigned CLK_DIV     = 4,
    parameter int unsigned H_ACTIVE    = VGA_H_ACTIVE,
    parameter int unsigned H_FP        = VGA_H_FP,
    parameter int unsigned H_SYNC      = VGA_H_SYNC,
    parameter int unsigned H_BP        = VGA_H_BP,
    parameter int unsigned V_ACTIVE    = VGA_V_ACTIVE,
    parameter int unsigned V_FP        = VGA_V_FP,
    parameter int unsigned V_SYNC      = VGA_V_SYNC,
    parameter int unsigned V_BP        = VGA_V_BP,
    parameter logic        SYNC_ACTIVE = VGA_SYNC_ACTIVE
) (
    input  logic                  clk,
    input  logic                  reset,
    vga_sync_generator_if.master  pix
);

    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_FIRST = H_ACTIVE + H_FP;
    localparam int unsigned HS_LAST  = HS_FIRST + H_SYNC - 1;
    localparam int unsigned VS_FIRST = V_ACTIVE + V_FP;
    localparam int unsigned VS_LAST  = VS_FIRST + V_SYNC - 1;

    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
        $error("vga_sync_generator: H_TOTAL and V_TOTAL must be <= 1024");
    end

    logic pixel_tick;

    pixel_clk_enable #(
        .CLK_DIV (CLK_DIV)
    ) u_pixel_clk_enable (
        .clk    (clk),
        .reset  (reset),
        .tick_o (pixel_tick)
    );

    logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
    logic               blank_q, blank_d;
    logic               hsync_q, hsync_d;
    logic               vsync_q, vsync_d;
    logic               frame_start_q, frame_start_d;
    logic               vblank_start_q, vblank_start_d;
    logic               x_last, y_last;

    always_comb begin
        x_d    = x_q;
        y_d    = y_q;
        x_last = (x_q == COORD_W'(H_TOTAL - 1));
        y_last = (y_q == COORD_W'(V_TOTAL - 1));
        if (pixel_tick) begin
            if (x_last) begin
                x_d = '0;
                y_d = y_last ? '0 : y_q + COORD_W'(1);
            end else begin
                x_d = x_q + COORD_W'(1);
            end
        end

        // Decoded from the next-state counters so the registered flags line
        // up with x_q/y_q on the same edge.
        blank_d = (x_d >= COORD_W'(H_ACTIVE)) || (y_d >= COORD_W'(V_ACTIVE));
        hsync_d = ((x_d >= COORD_W'(HS_FIRST)) && (x_d <= COORD_W'(HS_LAST)))
                  ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        vsync_d = ((y_d >= COORD_W'(VS_FIRST)) && (y_d <= COORD_W'(VS_LAST)))
                  ? SYNC_ACTIVE : ~SYNC_ACTIVE;

        // Pulses only on an advancing edge, so reset exit never fires them.
        frame_start_d  = pixel_tick && x_last && y_last;
        vblank_start_d = pixel_tick && x_last && (y_d == COORD_W'(V_ACTIVE));
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            x_q            <= '0;
            y_q            <= '0;
            blank_q        <= 1'b0;
            hsync_q        <= ~SYNC_ACTIVE;
            vsync_q        <= ~SYNC_ACTIVE;
            frame_start_q  <= 1'b0;
            vblank_start_q <= 1'b0;
        end else begin
            x_q            <= x_d;
            y_q            <= y_d;
            blank_q        <= blank_d;
            hsync_q        <= hsync_d;
            vsync_q        <= vsync_d;
            frame_start_q  <= frame_start_d;
            vblank_start_q <= vblank_start_d;
        end
    end

    assign pix.pixel_tick   = pixel_tick;
    assign pix.x            = x_q;
    assign pix.y            = y_q;
    assign pix.blank        = blank_q;
    assign pix.hsync        = hsync_q;
    assign pix.vsync        = vsync_q;
    assign pix.frame_start  = frame_start_q;
    assign pix.vblank_start = vblank_start_q;

endmodule

// File: tb/tb_vga_sync_generator.sv
// tb_vga_sync_generator: self-checking bench for vga_sync_generator.
//   u_d4 : default build (CLK_DIV = 4, 640x480 timing)
//   u_d1 : CLK_DIV = 1 build, default timing
//   u_ds : reduced timing (15x8 pixels, CLK_DIV = 2) to reach frame wraps
module tb_vga_sync_generator;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic rst_s_n;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    vga_sync_generator_if if4 ();
    vga_sync_generator_if if1 ();
    vga_sync_generator_if ifs ();

    vga_sync_generator #(.CLK_DIV(4)) u_d4 (
        .clk   (clk),
        .reset (rst_n),
        .pix   (if4)
    );

    vga_sync_generator #(.CLK_DIV(1)) u_d1 (
        .clk   (clk),
        .reset (rst_n),
        .pix   (if1)
    );

    vga_sync_generator #(
        .CLK_DIV  (2),
        .H_ACTIVE (8),
        .H_FP     (2),
        .H_SYNC   (3),
        .H_BP     (2),
        .V_ACTIVE (4),
        .V_FP     (1),
        .V_SYNC   (2),
        .V_BP     (1)
    ) u_ds (
        .clk   (clk),
        .reset (rst_s_n),
        .pix   (ifs)
    );

    task automatic check(input string tag, input int unsigned got,
                         input int unsigned exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int unsigned h4_low;
        int unsigned h1_low;
        int unsigned found;

        rst_n   = 1'b0;
        rst_s_n = 1'b0;
        repeat (3) step();

        check("rst_x",     if4.x, 0);
        check("rst_y",     if4.y, 0);
        check("rst_blank", if4.blank, 0);
        check("rst_hsync", if4.hsync, 1);
        check("rst_vsync", if4.vsync, 1);
        check("rst_tick",  if4.pixel_tick, 0);
        check("rst_fs",    if4.frame_start, 0);
        check("rst_vbs",   if4.vblank_start, 0);
        check("rst_tick1", if1.pixel_tick, 0);
        check("rst_hs_s",  ifs.hsync, 1);

        rst_n   = 1'b1;
        rst_s_n = 1'b1;
        step();  // release edge; now in cycle 0

        h4_low = 0;
        h1_low = 0;
        for (int unsigned c = 0; c < 3300; c++) begin
            int unsigned t4, ex4, ey4, ts, exs, eys;
            t4  = c / 4;
            ex4 = t4 % 800;
            ey4 = t4 / 800;
            check($sformatf("d4_tick@%0d", c), if4.pixel_tick, (c % 4) == 3);
            check($sformatf("d4_x@%0d", c), if4.x, ex4);
            check($sformatf("d4_y@%0d", c), if4.y, ey4);
            check($sformatf("d4_blank@%0d", c), if4.blank,
                  (ex4 >= 640) || (ey4 >= 480));
            check($sformatf("d4_hsync@%0d", c), if4.hsync,
                  (ex4 >= 656 && ex4 <= 751) ? 0 : 1);
            check($sformatf("d4_vsync@%0d", c), if4.vsync, 1);
            check($sformatf("d4_fs@%0d", c), if4.frame_start, 0);
            check($sformatf("d4_vbs@%0d", c), if4.vblank_start, 0);
            if (c < 3200 && if4.hsync == 1'b0) h4_low++;

            check($sformatf("d1_tick@%0d", c), if1.pixel_tick, 1);
            check($sformatf("d1_x@%0d", c), if1.x, c % 800);
            check($sformatf("d1_y@%0d", c), if1.y, c / 800);
            check($sformatf("d1_hsync@%0d", c), if1.hsync,
                  ((c % 800) >= 656 && (c % 800) <= 751) ? 0 : 1);
            if (c < 800 && if1.hsync == 1'b0) h1_low++;

            ts  = c / 2;
            exs = ts % 15;
            eys = (ts / 15) % 8;
            check($sformatf("ds_tick@%0d", c), ifs.pixel_tick, (c % 2) == 1);
            check($sformatf("ds_x@%0d", c), ifs.x, exs);
            check($sformatf("ds_y@%0d", c), ifs.y, eys);
            check($sformatf("ds_blank@%0d", c), ifs.blank,
                  (exs >= 8) || (eys >= 4));
            check($sformatf("ds_hsync@%0d", c), ifs.hsync,
                  (exs >= 10 && exs <= 12) ? 0 : 1);
            check($sformatf("ds_vsync@%0d", c), ifs.vsync,
                  (eys >= 5 && eys <= 6) ? 0 : 1);
            check($sformatf("ds_fs@%0d", c), ifs.frame_start,
                  ((c % 2) == 0) && ((ts % 120) == 0) && (ts > 0));
            check($sformatf("ds_vbs@%0d", c), ifs.vblank_start,
                  ((c % 2) == 0) && ((ts % 120) == 60));
            step();
        end
        check("d4_hsync_low_clks", h4_low, 384);
        check("d1_hsync_low_clks", h1_low, 96);

        // Reset asserted on the advancing edge of the last pixel of a frame.
        found = 0;
        for (int unsigned k = 0; k < 300 && found == 0; k++) begin
            if (ifs.pixel_tick && ifs.x == 14 && ifs.y == 7) found = 1;
            else step();
        end
        check("ds_find_last_pixel", found, 1);
        rst_s_n = 1'b0;
        step();
        check("mid_x",     ifs.x, 0);
        check("mid_y",     ifs.y, 0);
        check("mid_fs",    ifs.frame_start, 0);
        check("mid_vbs",   ifs.vblank_start, 0);
        check("mid_tick",  ifs.pixel_tick, 0);
        check("mid_blank", ifs.blank, 0);
        check("mid_hsync", ifs.hsync, 1);
        check("mid_vsync", ifs.vsync, 1);
        step();
        check("mid_fs2",   ifs.frame_start, 0);
        rst_s_n = 1'b1;
        step();  // release edge
        for (int unsigned c = 0; c < 8; c++) begin
            check($sformatf("re_tick@%0d", c), ifs.pixel_tick, (c % 2) == 1);
            check($sformatf("re_x@%0d", c), ifs.x, c / 2);
            check($sformatf("re_y@%0d", c), ifs.y, 0);
            check($sformatf("re_fs@%0d", c), ifs.frame_start, 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
